// File: rtl/two_pulses_pkg.sv
// Shared types and defaults for the two-pulse sequence generator.
// Holds the FSM state encoding and the default gap-counter width.
package two_pulses_pkg;

   localparam int GAP_W_DEFAULT = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      X_OPEN  = 3'd1,
      GAP     = 3'd2,
      Y_PULSE = 3'd3,
      X_CLOSE = 3'd4,
      DONE    = 3'd5
   } state_t;

endpackage

// File: rtl/pulse_gap_cnt.sv
// Loadable down-counter with zero flag, used to time the idle gap between pulses.
// A load takes priority over a decrement, and the count holds at zero once it gets there.
module pulse_gap_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);

   // NOTE: sequential state is written with non-blocking assignments only, so every
   // flop samples the pre-edge values and simulation matches the synthesized hardware.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/two_pulses_gen.sv
// Emits x, k y pulses, x, each separated by a programmable gap, then a done pulse.
// Config is captured when start is accepted, and every output comes straight from a flop.
module two_pulses_gen
   import two_pulses_pkg::*;
#(
   parameter int GAP_W = GAP_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [1:0]       y_cnt_i,
   input  logic [GAP_W-1:0] gap_i,
   output logic             x_o,
   output logic             y_o,
   output logic             busy_o,
   output logic             done_o
);

   state_t           state;
   logic [GAP_W-1:0] gap_cfg;
   logic [1:0]       y_rem;

   logic             gap_load;
   logic [GAP_W-1:0] gap_load_val;
   logic             gap_dec;
   logic [GAP_W-1:0] gap_cnt;
   logic             gap_zero;
   logic             advance;

   // The counter is loaded with gap-1, so the zero flag marks the last GAP cycle.
   // NOTE: every signal driven in always_comb gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      gap_load     = 1'b0;
      gap_load_val = gap_cfg - GAP_W'(1);
      gap_dec      = 1'b0;
      advance      = 1'b0;
      case (state)
         X_OPEN, Y_PULSE: begin
            gap_load = (gap_cfg != '0);
            advance  = (gap_cfg == '0);
         end
         GAP: begin
            gap_dec = 1'b1;
            advance = gap_zero;
         end
         default: ;
      endcase
   end

   pulse_gap_cnt #(.W(GAP_W)) u_gap_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (gap_load),
      .load_val (gap_load_val),
      .dec      (gap_dec),
      .cnt      (gap_cnt),
      .zero     (gap_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         gap_cfg <= '0;
         y_rem   <= 2'd0;
         x_o     <= 1'b0;
         y_o     <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
      end else begin
         x_o    <= 1'b0;
         y_o    <= 1'b0;
         done_o <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  state   <= X_OPEN;
                  gap_cfg <= gap_i;
                  y_rem   <= y_cnt_i;
                  x_o     <= 1'b1;
                  busy_o  <= 1'b1;
               end else begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            X_OPEN, Y_PULSE: begin
               if (!advance) begin
                  state <= GAP;
               end
            end
            GAP: ;
            X_CLOSE: begin
               state  <= DONE;
               busy_o <= 1'b0;
               done_o <= 1'b1;
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase

         // Next pulse: another y while any remain, otherwise the closing x.
         if (advance) begin
            if (y_rem != 2'd0) begin
               state <= Y_PULSE;
               y_o   <= 1'b1;
               y_rem <= y_rem - 2'd1;
            end else begin
               state <= X_CLOSE;
               x_o   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_two_pulses_gen.sv
// Directed bench for two_pulses_gen: per-cycle expectation masks for each scenario,
// followed by hand-written reset/start collision sequences.
module tb_two_pulses_gen;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_i = 1'b0;
   logic [1:0] y_cnt_i = 2'd0;
   logic [3:0] gap_i = 4'd0;
   logic       x_o, y_o, busy_o, done_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   two_pulses_gen #(.GAP_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .start_i (start_i),
      .y_cnt_i (y_cnt_i),
      .gap_i   (gap_i),
      .x_o     (x_o),
      .y_o     (y_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   // Bit c of each mask describes scenario cycle c (the cycle after edge c-1).
   typedef struct {
      string       name;
      int          ncyc;
      logic [1:0]  y_a;
      logic [3:0]  g_a;
      logic [1:0]  y_b;
      logic [3:0]  g_b;
      int          chg;
      logic [63:0] st;
      logic [63:0] rs;
      logic [63:0] xm;
      logic [63:0] ym;
      logic [63:0] bm;
      logic [63:0] dm;
   } scen_t;

   scen_t sc[8];

   function automatic logic [63:0] b(input int n);
      return 64'd1 << n;
   endfunction

   function automatic logic [63:0] rng(input int lo, input int hi);
      logic [63:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic scen_t mk(input string nm, input int n, input logic [1:0] ya,
                                input logic [3:0] ga, input logic [1:0] yb,
                                input logic [3:0] gb, input int chg,
                                input logic [63:0] st, input logic [63:0] rs,
                                input logic [63:0] xm, input logic [63:0] ym,
                                input logic [63:0] bm, input logic [63:0] dm);
      scen_t s;
      s.name = nm; s.ncyc = n; s.y_a = ya; s.g_a = ga; s.y_b = yb; s.g_b = gb;
      s.chg = chg; s.st = st; s.rs = rs; s.xm = xm; s.ym = ym; s.bm = bm; s.dm = dm;
      return s;
   endfunction

   task automatic check(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      sc[0] = mk("yc2_g0", 20, 2'd2, 4'd0, 2'd2, 4'd0, 63, b(10), '0,
                 b(11) | b(14), b(12) | b(13), rng(11, 14), b(15));
      sc[1] = mk("yc0_g3", 20, 2'd0, 4'd3, 2'd0, 4'd3, 63, b(10), '0,
                 b(11) | b(15), '0, rng(11, 15), b(16));
      sc[2] = mk("cfg_latch", 24, 2'd3, 4'd1, 2'd0, 4'd0, 13, b(10) | b(13), '0,
                 b(11) | b(19), b(13) | b(15) | b(17), rng(11, 19), b(20));
      sc[3] = mk("mid_reset", 34, 2'd2, 4'd2, 2'd2, 4'd2, 63, b(10) | b(20), b(16),
                 b(11) | b(21) | b(30), b(14) | b(24) | b(27),
                 rng(11, 16) | rng(21, 30), b(31));
      sc[4] = mk("b2b_start", 22, 2'd1, 4'd0, 2'd1, 4'd0, 63, rng(10, 14), '0,
                 b(11) | b(13) | b(15) | b(17), b(12) | b(16),
                 rng(11, 13) | rng(15, 17), b(14) | b(18));
      sc[5] = mk("gap_max", 38, 2'd1, 4'd15, 2'd1, 4'd15, 63, b(0), '0,
                 b(1) | b(33), b(17), rng(1, 33), b(34));
      sc[6] = mk("yc3_g0", 12, 2'd3, 4'd0, 2'd3, 4'd0, 63, b(2), '0,
                 b(3) | b(7), rng(4, 6), rng(3, 7), b(8));
      sc[7] = mk("yc0_g0", 8, 2'd0, 4'd0, 2'd0, 4'd0, 63, b(2), '0,
                 b(3) | b(4), '0, rng(3, 4), b(5));

      tick();
      for (int s = 0; s < 8; s++) begin
         reset   = 1'b1;
         start_i = 1'b0;
         tick();
         for (int c = 0; c < sc[s].ncyc; c++) begin
            reset   = sc[s].rs[c];
            start_i = sc[s].st[c];
            y_cnt_i = (c >= sc[s].chg) ? sc[s].y_b : sc[s].y_a;
            gap_i   = (c >= sc[s].chg) ? sc[s].g_b : sc[s].g_a;
            check($sformatf("%s c%0d x_o", sc[s].name, c), x_o, sc[s].xm[c]);
            check($sformatf("%s c%0d y_o", sc[s].name, c), y_o, sc[s].ym[c]);
            check($sformatf("%s c%0d busy_o", sc[s].name, c), busy_o, sc[s].bm[c]);
            check($sformatf("%s c%0d done_o", sc[s].name, c), done_o, sc[s].dm[c]);
            check($sformatf("%s c%0d xy_excl", sc[s].name, c), x_o & y_o, 1'b0);
            tick();
         end
      end

      // Start asserted on the same edge as reset must not launch a sequence.
      reset = 1'b1; start_i = 1'b1; y_cnt_i = 2'd1; gap_i = 4'd0;
      tick();
      reset = 1'b0; start_i = 1'b0;
      check("rst_start x_o", x_o, 1'b0);
      check("rst_start busy_o", busy_o, 1'b0);
      tick();
      check("rst_start next x_o", x_o, 1'b0);
      check("rst_start next busy_o", busy_o, 1'b0);

      // Reset together with start in the middle of a sequence.
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("launch x_o", x_o, 1'b1);
      check("launch busy_o", busy_o, 1'b1);
      reset = 1'b1; start_i = 1'b1;
      tick();
      reset = 1'b0; start_i = 1'b0;
      check("mid_rst x_o", x_o, 1'b0);
      check("mid_rst y_o", y_o, 1'b0);
      check("mid_rst busy_o", busy_o, 1'b0);
      check("mid_rst done_o", done_o, 1'b0);
      tick();
      check("mid_rst idle busy_o", busy_o, 1'b0);
      check("mid_rst idle y_o", y_o, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
